// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared constants for the slide-switch conditioning stage: default bus width,
// the system clock rate and the debounce window derived from it.
// No ports; imported by debounce_bit and switch_debouncer.
// -----------------------------------------------------------------------------
package switch_pkg;

    // DE1-SoC board clock feeding the switch PIO.
    localparam int CLK_HZ      = 50_000_000;

    // Settling time a mechanical slide switch is given before it is trusted.
    localparam int DEBOUNCE_MS = 10;

    // Eight slide switches on the board.
    localparam int WIDTH_DEFAULT = 8;

    // 10 ms at 50 MHz = 500000 cycles.
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage : switch_pkg

// File: rtl/switch_debouncer_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One switch channel: two-flop synchronizer, run-length counter, debounced
// bit and registered rise/fall pulses.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high; clears every flop
//   raw          asynchronous raw switch pin
//   db           debounced level
//   rise         one-cycle pulse on db 0->1, coincident with the new db
//   fall         one-cycle pulse on db 1->0, coincident with the new db
//   accept_next  combinational: db changes on the coming edge (used by the
//                top to register the summary change strobe in step with
//                rise/fall)
// -----------------------------------------------------------------------------
module debounce_bit
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic accept_next
);

    // Terminal count: the synchronized level has disagreed with db for a
    // full window once cnt reaches this value and still disagrees.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    assign accept_next = (sync2 != db) && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            // Plain flop-to-flop path so the pair acts as a metastability filter.
            sync1 <= raw;
            sync2 <= sync1;

            rise  <= 1'b0;
            fall  <= 1'b0;

            if (sync2 == db) begin
                // Any return to the accepted level discards the partial run.
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db   <= sync2;
                cnt  <= '0;
                rise <= sync2;
                fall <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// Conditions the raw DE1-SoC slide switches for the switch PIO: each bit is
// synchronized into clk and debounced independently. Also provides per-bit
// edge pulses and a summary change strobe for edge-capture/interrupt logic.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   sw_raw     asynchronous raw switch pins
//   sw_db      debounced switch value (to PIO in_port)
//   sw_rise    per-bit one-cycle pulse on sw_db 0->1
//   sw_fall    per-bit one-cycle pulse on sw_db 1->0
//   sw_change  one-cycle pulse whenever any bit of sw_db changes
//
// DEBOUNCE_CYCLES must be at least 2.
// -----------------------------------------------------------------------------
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_change
);

    logic [WIDTH-1:0] accept_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .raw         (sw_raw[i]),
            .db          (sw_db[i]),
            .rise        (sw_rise[i]),
            .fall        (sw_fall[i]),
            .accept_next (accept_next[i])
        );
    end

    // Registered from the channels' next-edge accepts so the strobe lines up
    // exactly with the rise/fall pulses rather than trailing them by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_change <= 1'b0;
        end else begin
            sw_change <= |accept_next;
        end
    end

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
// Self-checking bench for switch_debouncer with DEBOUNCE_CYCLES = 4.
// The reference keeps the last DEBOUNCE_CYCLES synchronized samples per bit
// and accepts a new level when all of them disagree with the accepted value.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

    localparam int W  = 8;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_change;

    int errors = 0;
    int checks = 0;

    switch_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .sw_db     (sw_db),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_change (sw_change)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [W-1:0] m_s1, m_s2, m_db, m_rise, m_fall;
    logic         m_chg;
    logic [W-1:0] hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst_i, input logic [W-1:0] raw);
        logic [W-1:0] acc;
        logic [W-1:0] nxt;
        if (rst_i) begin
            m_s1 = '0; m_s2 = '0; m_db = '0;
            m_rise = '0; m_fall = '0; m_chg = 1'b0;
            hist = {};
            for (int i = 0; i < DC; i++) hist.push_back('0);
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > DC) void'(hist.pop_front());
            for (int b = 0; b < W; b++) begin
                acc[b] = 1'b1;
                foreach (hist[k]) if (hist[k][b] == m_db[b]) acc[b] = 1'b0;
            end
            nxt    = m_db ^ acc;
            m_rise = acc & nxt;
            m_fall = acc & ~nxt;
            m_chg  = |acc;
            m_db   = nxt;
            m_s2   = m_s1;
            m_s1   = raw;
        end
    endtask

    // One clock edge: update the reference with the inputs present at the
    // edge, then compare a little after it.
    task automatic tick();
        @(posedge clk);
        model_edge(reset, sw_raw);
        #1;
        chk("db",     {24'd0, sw_db},   {24'd0, m_db});
        chk("rise",   {24'd0, sw_rise}, {24'd0, m_rise});
        chk("fall",   {24'd0, sw_fall}, {24'd0, m_fall});
        chk("change", {31'd0, sw_change}, {31'd0, m_chg});
    endtask

    task automatic do_reset(input logic [W-1:0] raw, input int n);
        reset  = 1'b1;
        sw_raw = raw;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("rst_db",    {24'd0, sw_db}, 32'h0);
            chk("rst_pulse", {24'd0, sw_rise | sw_fall}, 32'h0);
            chk("rst_chg",   {31'd0, sw_change}, 32'h0);
        end
        reset = 1'b0;
    endtask

    // Drive raw and expect sw_db to hold old_db for n-1 edges, then take the
    // new value on edge n with the given pulses, then pulses clear.
    task automatic expect_update(input string tag, input logic [W-1:0] raw, input int n,
                                 input logic [W-1:0] old_db, input logic [W-1:0] new_db,
                                 input logic [W-1:0] rise_e, input logic [W-1:0] fall_e);
        sw_raw = raw;
        for (int i = 1; i < n; i++) begin
            tick();
            chk({tag, "_hold"}, {24'd0, sw_db}, {24'd0, old_db});
            chk({tag, "_quiet"}, {31'd0, sw_change}, 32'h0);
        end
        tick();
        chk({tag, "_db"},   {24'd0, sw_db},   {24'd0, new_db});
        chk({tag, "_rise"}, {24'd0, sw_rise}, {24'd0, rise_e});
        chk({tag, "_fall"}, {24'd0, sw_fall}, {24'd0, fall_e});
        chk({tag, "_chg"},  {31'd0, sw_change}, 32'h1);
        tick();
        chk({tag, "_rise_end"}, {24'd0, sw_rise | sw_fall}, 32'h0);
        chk({tag, "_chg_end"},  {31'd0, sw_change}, 32'h0);
    endtask

    task automatic expect_quiet(input string tag, input int n, input logic [W-1:0] held);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_db"},  {24'd0, sw_db}, {24'd0, held});
            chk({tag, "_chg"}, {31'd0, sw_change}, 32'h0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        sw_raw = '0;

        // Switches high through reset: accepted six edges after release.
        do_reset(8'hFF, 3);
        expect_update("pwrup", 8'hFF, 6, 8'h00, 8'hFF, 8'hFF, 8'h00);
        expect_quiet("held_ff", 8, 8'hFF);

        // Clean single-bit rise.
        do_reset(8'h00, 2);
        expect_quiet("idle", 4, 8'h00);
        expect_update("clean", 8'h01, 6, 8'h00, 8'h01, 8'h01, 8'h00);

        // Bouncing bit 3, then a stable 1.
        do_reset(8'h00, 2);
        expect_quiet("idle2", 4, 8'h00);
        sw_raw = 8'h08; tick();
        sw_raw = 8'h00; tick();
        sw_raw = 8'h08; tick();
        sw_raw = 8'h00; tick();
        chk("bounce_db", {24'd0, sw_db}, 32'h0);
        expect_update("bounce", 8'h08, 6, 8'h00, 8'h08, 8'h08, 8'h00);

        // Bit 7 high for three samples: rejected.
        do_reset(8'h00, 2);
        expect_quiet("idle3", 4, 8'h00);
        sw_raw = 8'h80;
        for (int i = 0; i < 3; i++) tick();
        sw_raw = 8'h00;
        expect_quiet("glitch3", 10, 8'h00);
        // Four samples: accepted on edge 6, then the fall follows.
        sw_raw = 8'h80;
        for (int i = 0; i < 4; i++) tick();
        sw_raw = 8'h00;
        tick();
        chk("glitch4_db_pre", {24'd0, sw_db}, 32'h0);
        tick();
        chk("glitch4_db",   {24'd0, sw_db},   32'h80);
        chk("glitch4_rise", {24'd0, sw_rise}, 32'h80);
        expect_update("glitch4_fall", 8'h00, 4, 8'h80, 8'h00, 8'h00, 8'h80);

        // Simultaneous rise and fall on different bits.
        do_reset(8'h00, 2);
        expect_update("to0f", 8'h0F, 6, 8'h00, 8'h0F, 8'h0F, 8'h00);
        expect_update("simul", 8'hF0, 6, 8'h0F, 8'hF0, 8'hF0, 8'h0F);

        // Reset in the middle of a count, input kept high.
        do_reset(8'h00, 2);
        expect_quiet("idle4", 4, 8'h00);
        sw_raw = 8'h04;
        for (int i = 0; i < 4; i++) tick();
        chk("midcnt_db", {24'd0, sw_db}, 32'h0);
        do_reset(8'h04, 2);
        tick();
        chk("post_rst_pulse", {24'd0, sw_rise | sw_fall}, 32'h0);
        chk("post_rst_chg",   {31'd0, sw_change}, 32'h0);
        expect_update("midrst", 8'h04, 5, 8'h00, 8'h04, 8'h04, 8'h00);

        // Random activity with occasional resets against the reference.
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] flip;
            for (int b = 0; b < W; b++) flip[b] = ($urandom_range(0, 5) == 0);
            sw_raw = sw_raw ^ flip;
            reset  = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_switch_debouncer
